// File: rtl/execute_pipe.sv
// -----------------------------------------------------------------------------
// execute_pipe
//
// Parametrised execute stage sitting between decode and memory. Single-cycle
// operations (ALU, branch target, load/store address) are registered on the
// accept edge. OP_MUL_D runs on an unsigned radix-2 shift-add multiplier that
// retires one multiplier bit per cycle. Both sides use a valid/stall handshake,
// and a flush kills the in-flight instruction and the output register.
//
// All state updates on the falling edge of I_CLOCK, matching the rest of the
// pipeline. I_RESET is asynchronous and active-high.
//
// Ports
//   I_CLOCK, I_RESET             clock (negedge active), async active-high reset
//   I_Valid / O_Ready            upstream handshake; O_Ready is combinational
//   I_PC                         PC of the instruction (PC_WIDTH bits)
//   I_Opcode                     opcode (OPCODE_WIDTH bits)
//   I_Src1Value, I_Src2Value     register operands (REG_WIDTH bits)
//   I_Imm                        sign-extended immediate (REG_WIDTH bits)
//   I_DestRegIdx                 destination register index (IDX_WIDTH bits)
//   I_FetchStall, I_DepStall     sideband flags carried with the instruction
//   I_Flush                      kill in-flight instruction and output
//   I_Stall                      memory stage cannot take the output
//   O_Valid                      output registers hold a result
//   O_ALUOut                     address / branch-target result
//   O_DestValue                  register write-back result
//   O_Opcode, O_DestRegIdx,
//   O_FetchStall, O_DepStall     registered copies of the instruction fields
//   O_Busy                       multiplier iterating
// -----------------------------------------------------------------------------
module execute_pipe #(
  parameter int REG_WIDTH    = 16,
  parameter int PC_WIDTH     = 16,   // must not exceed REG_WIDTH
  parameter int OPCODE_WIDTH = 8,
  parameter int IDX_WIDTH    = 4
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_Valid,
  output logic                    O_Ready,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_Src1Value,
  input  logic [REG_WIDTH-1:0]    I_Src2Value,
  input  logic [REG_WIDTH-1:0]    I_Imm,
  input  logic [IDX_WIDTH-1:0]    I_DestRegIdx,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_Flush,
  input  logic                    I_Stall,
  output logic                    O_Valid,
  output logic [REG_WIDTH-1:0]    O_ALUOut,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [IDX_WIDTH-1:0]    O_DestRegIdx,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic                    O_Busy
);

  // ---------------------------------------------------------------------------
  // Opcode encodings, mirroring global_def.h.
  // ---------------------------------------------------------------------------
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = OPCODE_WIDTH'(8'h11);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = OPCODE_WIDTH'(8'h12);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = OPCODE_WIDTH'(8'h13);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL_D  = OPCODE_WIDTH'(8'h14);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = OPCODE_WIDTH'(8'h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = OPCODE_WIDTH'(8'h21);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN    = OPCODE_WIDTH'(8'h30);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ    = OPCODE_WIDTH'(8'h31);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRP    = OPCODE_WIDTH'(8'h32);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ   = OPCODE_WIDTH'(8'h33);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNP   = OPCODE_WIDTH'(8'h34);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZP   = OPCODE_WIDTH'(8'h35);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP  = OPCODE_WIDTH'(8'h36);
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = OPCODE_WIDTH'(8'h40);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = OPCODE_WIDTH'(8'h50);
  localparam logic [OPCODE_WIDTH-1:0] OP_STW    = OPCODE_WIDTH'(8'h51);

  // Iteration counter: loaded with REG_WIDTH-1, completion on the 0 edge.
  localparam int CNT_W = (REG_WIDTH > 2) ? $clog2(REG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,   state_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [REG_WIDTH-1:0]    acc_q,     acc_d;     // partial product
  logic [REG_WIDTH-1:0]    mcand_q,   mcand_d;   // multiplicand, shifts left
  logic [REG_WIDTH-1:0]    mplier_q,  mplier_d;  // multiplier, shifts right
  logic [IDX_WIDTH-1:0]    mul_idx_q, mul_idx_d;
  logic                    mul_fs_q,  mul_fs_d;
  logic                    mul_ds_q,  mul_ds_d;

  logic                    valid_q,   valid_d;
  logic [REG_WIDTH-1:0]    alu_q,     alu_d;
  logic [REG_WIDTH-1:0]    dest_q,    dest_d;
  logic [OPCODE_WIDTH-1:0] op_q,      op_d;
  logic [IDX_WIDTH-1:0]    idx_q,     idx_d;
  logic                    fs_q,      fs_d;
  logic                    ds_q,      ds_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic busy;
  logic ready;
  logic accept;
  logic consume;
  logic out_free;

  assign busy     = (state_q == ST_MUL);
  assign ready    = !busy && !(valid_q && I_Stall);
  assign accept   = I_Valid && ready && !I_Flush;
  assign consume  = valid_q && !I_Stall;
  // The output register can take a new result if empty or drained this edge.
  assign out_free = !valid_q || !I_Stall;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [REG_WIDTH-1:0] pc_ext;
  logic [REG_WIDTH-1:0] br_target;
  logic [REG_WIDTH-1:0] alu_res;
  logic [REG_WIDTH-1:0] dest_res;

  // PC is zero-extended; the immediate is a word offset, hence the << 2.
  assign pc_ext    = REG_WIDTH'(I_PC);
  assign br_target = pc_ext + (I_Imm << 2);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    alu_res  = '0;
    dest_res = '0;
    case (I_Opcode)
      OP_ADD_D:  dest_res = I_Src1Value + I_Src2Value;
      OP_ADDI_D: dest_res = I_Src1Value + I_Imm;
      OP_AND_D:  dest_res = I_Src1Value & I_Src2Value;
      OP_ANDI_D: dest_res = I_Src1Value & I_Imm;
      OP_MOV:    dest_res = I_Src1Value;
      OP_MOVI_D: dest_res = I_Imm;
      OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRNP, OP_BRZP, OP_BRNZP, OP_JSR:
                 alu_res  = br_target;
      OP_LDW, OP_STW:
                 alu_res  = I_Src1Value + I_Imm;
      default: begin
        alu_res  = '0;
        dest_res = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier step: add the multiplicand when the current multiplier bit is 1.
  // ---------------------------------------------------------------------------
  logic [REG_WIDTH-1:0] acc_sum;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_idx_d = mul_idx_q;
    mul_fs_d  = mul_fs_q;
    mul_ds_d  = mul_ds_q;
    valid_d   = valid_q;
    alu_d     = alu_q;
    dest_d    = dest_q;
    op_d      = op_q;
    idx_d     = idx_q;
    fs_d      = fs_q;
    ds_d      = ds_q;

    if (I_Flush) begin
      // Flush beats accept, stall and multiply completion.
      valid_d = 1'b0;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      if (consume) begin
        valid_d = 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (I_Opcode == OP_MUL_D) begin
              state_d   = ST_MUL;
              cnt_d     = CNT_LOAD;
              acc_d     = '0;
              mcand_d   = I_Src1Value;
              mplier_d  = I_Src2Value;
              mul_idx_d = I_DestRegIdx;
              mul_fs_d  = I_FetchStall;
              mul_ds_d  = I_DepStall;
            end else begin
              valid_d = 1'b1;
              alu_d   = alu_res;
              dest_d  = dest_res;
              op_d    = I_Opcode;
              idx_d   = I_DestRegIdx;
              fs_d    = I_FetchStall;
              ds_d    = I_DepStall;
            end
          end
        end

        ST_MUL: begin
          if (cnt_q != '0) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_ONE;
          end else if (out_free) begin
            // Last step folds straight into the output register.
            state_d = ST_RUN;
            valid_d = 1'b1;
            alu_d   = '0;
            dest_d  = acc_sum;
            op_d    = OP_MUL_D;
            idx_d   = mul_idx_q;
            fs_d    = mul_fs_q;
            ds_d    = mul_ds_q;
          end
          // Otherwise hold at count 0 with the accumulator untouched until the
          // output register frees up.
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers (negedge clocked, async active-high reset)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the multiplier operand registers are reset along with the control
  // state; there are only a few of them and it keeps X out of the datapath.
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      mul_idx_q <= '0;
      mul_fs_q  <= 1'b0;
      mul_ds_q  <= 1'b0;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      dest_q    <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
      ds_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mul_idx_q <= mul_idx_d;
      mul_fs_q  <= mul_fs_d;
      mul_ds_q  <= mul_ds_d;
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      dest_q    <= dest_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
      ds_q      <= ds_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign O_Ready      = ready;
  assign O_Busy       = busy;
  assign O_Valid      = valid_q;
  assign O_ALUOut     = alu_q;
  assign O_DestValue  = dest_q;
  assign O_Opcode     = op_q;
  assign O_DestRegIdx = idx_q;
  assign O_FetchStall = fs_q;
  assign O_DepStall   = ds_q;

endmodule
